// File: rtl/adb_mouse_dev.sv
// ADB mouse device: accumulates PS/2 motion and button state, answers decoded
// ADB Talk/Listen/Flush/SendReset commands with 16-bit register words, and
// raises a service request while motion or a button change is unreported.
module adb_mouse_dev #(
    parameter logic [3:0] DEF_ADDR    = 4'h3,
    parameter logic [7:0] DEF_HANDLER = 8'h01,
    parameter int         ACC_W       = 10
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        m_strobe,
    input  logic [8:0]  mouseX,
    input  logic [8:0]  mouseY,
    input  logic        button,
    input  logic        cmd_strobe,
    input  logic [7:0]  cmd,
    input  logic [15:0] listen_data,
    output logic        talk_valid,
    output logic [15:0] talk_data,
    input  logic        talk_ack,
    input  logic        talk_abort,
    output logic        talk_nodata,
    output logic        srq
);

    typedef enum logic {S_IDLE, S_TALK} state_t;
    state_t state, state_nx;

    logic [ACC_W-1:0] accx, accy;
    logic [3:0]       addr;
    logic [7:0]       handler;
    logic             srq_en, last_btn;
    logic [6:0]       snap_dx, snap_dy;
    logic             snap_b, talk_r0;

    logic             match, pending, commit;
    logic             do_reset, do_flush, do_talk0, do_talk3, do_talk12, do_listen3;
    logic [ACC_W:0]   mx_e, my_e, dx_e, dy_e, sumx, sumy;
    logic [6:0]       dx_c, dy_c;

    // Listen R3 only looks at the address, srq enable and handler fields.
    logic unused_ok;
    assign unused_ok = &{1'b0, listen_data[15:14], listen_data[12]};

    // Two's-complement saturation of a one-bit-wider sum back to ACC_W.
    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] v);
        if (v[ACC_W] ^ v[ACC_W-1])
            sat = v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat = v[ACC_W-1:0];
    endfunction

    // Clamp a signed accumulator to the 7-bit ADB delta range -64..63.
    function automatic logic [6:0] clamp7(input logic [ACC_W-1:0] v);
        if (!v[ACC_W-1] && (|v[ACC_W-2:6]))
            clamp7 = 7'h3f;
        else if (v[ACC_W-1] && !(&v[ACC_W-2:6]))
            clamp7 = 7'h40;
        else
            clamp7 = v[6:0];
    endfunction

    // Command decode, pending detection and next accumulator sums.
    always_comb begin
        match      = (cmd[7:4] == addr);
        do_reset   = cmd_strobe && (cmd == 8'h00);
        do_flush   = cmd_strobe && match && (cmd[3:0] == 4'b0001);
        do_talk0   = cmd_strobe && match && (cmd[3:0] == 4'b1100);
        do_talk3   = cmd_strobe && match && (cmd[3:0] == 4'b1111);
        do_talk12  = cmd_strobe && match && (cmd[3:2] == 2'b11) && (cmd[1] ^ cmd[0]);
        do_listen3 = cmd_strobe && match && (cmd[3:0] == 4'b1011);
        pending    = (|accx) || (|accy) || (button != last_btn);
        // A new command while talking is an implicit abort, so it never commits.
        commit     = (state == S_TALK) && talk_r0 && talk_ack && !talk_abort && !cmd_strobe;
        mx_e       = m_strobe ? {{(ACC_W-8){mouseX[8]}}, mouseX} : '0;
        my_e       = m_strobe ? {{(ACC_W-8){mouseY[8]}}, mouseY} : '0;
        dx_e       = commit ? {{(ACC_W-6){snap_dx[6]}}, snap_dx} : '0;
        dy_e       = commit ? {{(ACC_W-6){snap_dy[6]}}, snap_dy} : '0;
        // Y is negated: PS/2 is +up, ADB is +down.
        sumx       = {accx[ACC_W-1], accx} + mx_e - dx_e;
        sumy       = {accy[ACC_W-1], accy} - my_e - dy_e;
        dx_c       = clamp7(accx);
        dy_c       = clamp7(accy);
    end

    // FSM state register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)       state <= S_IDLE;
        else if (clk_en) state <= state_nx;
    end

    // FSM next state: ack/abort/new command end a talk; a talk with data starts one.
    always_comb begin
        state_nx = state;
        if (state == S_TALK && (talk_ack || talk_abort || cmd_strobe))
            state_nx = S_IDLE;
        if ((do_talk0 && pending) || do_talk3)
            state_nx = S_TALK;
    end

    // FSM outputs.
    always_comb begin
        talk_valid = (state == S_TALK);
    end

    // Accumulators, device registers, snapshot and registered status outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            accx        <= '0;
            accy        <= '0;
            addr        <= DEF_ADDR;
            handler     <= DEF_HANDLER;
            srq_en      <= 1'b1;
            last_btn    <= 1'b1;
            snap_dx     <= '0;
            snap_dy     <= '0;
            snap_b      <= 1'b1;
            talk_r0     <= 1'b0;
            talk_data   <= '0;
            talk_nodata <= 1'b0;
            srq         <= 1'b0;
        end else if (clk_en) begin
            talk_nodata <= (do_talk0 && !pending) || do_talk12;
            srq         <= pending && srq_en;
            if (do_reset || do_flush) begin
                accx     <= '0;
                accy     <= '0;
                last_btn <= button;
            end else begin
                if (m_strobe || commit) begin
                    accx <= sat(sumx);
                    accy <= sat(sumy);
                end
                if (commit) last_btn <= snap_b;
            end
            if (do_reset) begin
                addr    <= DEF_ADDR;
                handler <= DEF_HANDLER;
                srq_en  <= 1'b1;
            end else if (do_listen3) begin
                case (listen_data[7:0])
                    8'h00: begin
                        addr   <= listen_data[11:8];
                        srq_en <= listen_data[13];
                    end
                    8'hfe:        addr    <= listen_data[11:8];
                    8'h01, 8'h02: handler <= listen_data[7:0];
                    default: ;
                endcase
            end
            if (do_talk0 && pending) begin
                snap_dx   <= dx_c;
                snap_dy   <= dy_c;
                snap_b    <= button;
                talk_r0   <= 1'b1;
                talk_data <= {button, dy_c, 1'b1, dx_c};
            end else if (do_talk3) begin
                talk_r0   <= 1'b0;
                talk_data <= {2'b01, srq_en, 1'b0, addr, handler};
            end
        end
    end

endmodule
